ext_alu_core: RTL and testbench
===============================

EXT_ALU_CORE -- requirements
Module: ext_alu_core

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from define.vh (ALUDATABITS=32, ALUOPBITS=4, ALUCSRINBITS=3, ALUCSROUTBITS=3).
REQ-002 The block SHALL have a single clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-003 The block SHALL have a reset port, reset, input, 1 bit, which is asynchronous and active-high.
REQ-004 The block SHALL have OP1, input, 32 bits: first operand, valid while CSR_ALU_IN[1]=1.
REQ-005 The block SHALL have OP2, input, 32 bits: second operand, valid while CSR_ALU_IN[2]=1.
REQ-006 The block SHALL have ALUOP, input, 4 bits: operation code, sampled together with OP1.
REQ-007 The block SHALL have CSR_ALU_IN, input, 3 bits: [0] result protect, [1] OP1 stable, [2] OP2 stable.
REQ-008 The block SHALL have OP3, output, 32 bits: registered result.
REQ-009 The block SHALL have CSR_ALU_OUT, output, 3 bits: [0] OP1 port ready, [1] OP2 port ready, [2] result valid.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, GET_OP2, EXEC, WRITE and HOLD; CSR_ALU_OUT SHALL be registered and SHALL be 3'b001 in IDLE, 3'b010 in GET_OP2, 3'b000 in EXEC and WRITE, and 3'b100 in HOLD.
REQ-011 In IDLE, when CSR_ALU_IN[1]=1, the block SHALL latch OP1 and ALUOP and move to GET_OP2.
REQ-012 If CSR_ALU_IN[1] and CSR_ALU_IN[2] are both 1 in IDLE, only OP1 SHALL be taken.
REQ-013 In GET_OP2, when CSR_ALU_IN[2]=1, the block SHALL latch OP2, load the execution counter and move to EXEC.
REQ-014 The block SHALL ignore CSR_ALU_IN[1] outside IDLE and CSR_ALU_IN[2] outside GET_OP2.
REQ-015 EXEC SHALL last 1 cycle for single-cycle ops and exactly 32 cycles for MUL, DIVU and REMU, then move to WRITE.
REQ-016 In WRITE, the block SHALL stall while CSR_ALU_IN[0]=1; when CSR_ALU_IN[0]=0, it SHALL register OP3 from the result, set CSR_ALU_OUT[2], and move to HOLD.
REQ-017 OP3 SHALL be written only in WRITE with CSR_ALU_IN[0]=0, so a protected result is never overwritten.
REQ-018 In HOLD, when CSR_ALU_IN[0]=1, the block SHALL clear CSR_ALU_OUT[2] and return to IDLE; OP3 SHALL retain its value.
REQ-019 For a single-cycle op, with the IN[2] sample at edge E0 and protect low, OP3 and OUT[2] SHALL update at edge E0+2; for MUL, DIVU and REMU they SHALL update at E0+33.
REQ-020 ALUOP encoding (opcode: operation -> result):
  - 0: ADD; 1: SUB; 2: AND; 3: OR; 4: XOR.
  - 5: SLL, 6: SRL, 7: SRA, with shift amount OP2[4:0].
  - 8: SLT (signed); 9: SLTU, each giving 32'd1 or 32'd0.
  - 10: MUL, low 32 bits of the unsigned product.
  - 12: DIVU; 13: REMU.
  - 11, 14, 15: result 0, single-cycle.
REQ-021 All arithmetic SHALL be 32-bit with wrap-around; carries and overflow SHALL be discarded.
REQ-022 For divide by zero, DIVU SHALL return 32'hFFFFFFFF and REMU SHALL return OP1, and each SHALL still take 32 cycles.

Reset
REQ-023 Reset SHALL immediately force state=IDLE, CSR_ALU_OUT=3'b001, OP3=0, all latched operands and counters to 0, and the iterative unit to idle.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no partial OP3 update; after release, the first IN[1] pulse SHALL start a fresh operation.

Structure
REQ-025 define.vh SHALL hold the ALUOP code constants, the CSR_ALU_IN/OUT bit indices and the iteration count (32).
REQ-026 The shift-add multiplier and restoring divider SHALL be one sub-module, ext_alu_seqmd, with start, op, a, b, done and result ports; the single-cycle ops SHALL be combinational in ext_alu_core.

Verification
REQ-027 ADD: OP1=5, OP2=7 -> OP3=12 and OUT[2]=1 at E0+2; then IN[0]=1 -> OUT=3'b001 on the next edge.
REQ-028 SUB: 3-5 -> 32'hFFFFFFFE; SLT with OP1=32'hFFFFFFFF, OP2=1 -> 1; SLTU with the same operands -> 0; SRA of 32'h80000000 by 4 -> 32'hF8000000.
REQ-029 MUL: 1234*5678 -> 7006652 at E0+33; 32'h10000*32'h10000 -> 0.
REQ-030 DIVU: 100/7 -> 14; REMU -> 2; DIVU by 0 -> 32'hFFFFFFFF; REMU 9 by 0 -> 9.
REQ-031 Protect: hold IN[0]=1 through EXEC with prior OP3=12 -> block stalls in WRITE, OUT[2]=0 and OP3=12; drop IN[0] -> new result on the next edge.
REQ-032 Reset at cycle 10 of a MUL -> OUT=3'b001 and OP3=0 without a clock edge; IN[2] pulses arriving before any IN[1] are ignored.

Source files
------------

// File: rtl/ext_alu_core_pkg.sv
// Shared widths, opcode constants, CSR bit positions and FSM types for the
// external ALU core and its iterative multiply/divide unit.
package ext_alu_core_pkg;

  localparam int ALU_DATA_BITS    = 32;
  localparam int ALU_OP_BITS      = 4;
  localparam int ALU_CSR_IN_BITS  = 3;
  localparam int ALU_CSR_OUT_BITS = 3;
  localparam int ITER_COUNT       = 32;

  localparam int CSR_IN_PROTECT  = 0;
  localparam int CSR_IN_OP1      = 1;
  localparam int CSR_IN_OP2      = 2;
  localparam int CSR_OUT_OP1_RDY = 0;
  localparam int CSR_OUT_OP2_RDY = 1;
  localparam int CSR_OUT_VALID   = 2;

  localparam logic [ALU_OP_BITS-1:0] OP_ADD  = 4'd0;
  localparam logic [ALU_OP_BITS-1:0] OP_SUB  = 4'd1;
  localparam logic [ALU_OP_BITS-1:0] OP_AND  = 4'd2;
  localparam logic [ALU_OP_BITS-1:0] OP_OR   = 4'd3;
  localparam logic [ALU_OP_BITS-1:0] OP_XOR  = 4'd4;
  localparam logic [ALU_OP_BITS-1:0] OP_SLL  = 4'd5;
  localparam logic [ALU_OP_BITS-1:0] OP_SRL  = 4'd6;
  localparam logic [ALU_OP_BITS-1:0] OP_SRA  = 4'd7;
  localparam logic [ALU_OP_BITS-1:0] OP_SLT  = 4'd8;
  localparam logic [ALU_OP_BITS-1:0] OP_SLTU = 4'd9;
  localparam logic [ALU_OP_BITS-1:0] OP_MUL  = 4'd10;
  localparam logic [ALU_OP_BITS-1:0] OP_DIVU = 4'd12;
  localparam logic [ALU_OP_BITS-1:0] OP_REMU = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_OP2,
    ST_EXEC,
    ST_WRITE,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_op_e;

  function automatic logic is_iterative(input logic [ALU_OP_BITS-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic [ALU_CSR_OUT_BITS-1:0] csr_out_code(input state_e s);
    logic [ALU_CSR_OUT_BITS-1:0] code;
    code = '0;
    case (s)
      ST_IDLE:    code[CSR_OUT_OP1_RDY] = 1'b1;
      ST_GET_OP2: code[CSR_OUT_OP2_RDY] = 1'b1;
      ST_HOLD:    code[CSR_OUT_VALID]   = 1'b1;
      default:    code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ext_alu_core_seqmd.sv
// Iterative unit: shift-add multiplier and restoring divider, one bit per cycle
// for ITER_COUNT cycles after a start pulse.
module ext_alu_seqmd
  import ext_alu_core_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  md_op_e                   op,
  input  logic [ALU_DATA_BITS-1:0] a,
  input  logic [ALU_DATA_BITS-1:0] b,
  output logic                     done,
  output logic [ALU_DATA_BITS-1:0] result
);

  md_op_e                   op_q;
  logic [ALU_DATA_BITS-1:0] acc;
  logic [ALU_DATA_BITS-1:0] x;
  logic [ALU_DATA_BITS-1:0] y;
  logic [5:0]               cnt;
  logic                     busy;

  logic [ALU_DATA_BITS:0]   rem_shift;
  logic                     fits;
  logic [ALU_DATA_BITS-1:0] rem_next;

  // Divide-by-zero needs no special case: every trial subtract fits, giving an
  // all-ones quotient while the remainder accumulates the dividend bits.
  always_comb begin
    rem_shift = {acc, x[ALU_DATA_BITS-1]};
    fits      = (rem_shift >= {1'b0, y});
    rem_next  = fits ? ALU_DATA_BITS'(rem_shift - {1'b0, y}) : rem_shift[ALU_DATA_BITS-1:0];
  end

  // acc is the product (MUL) or partial remainder; x holds multiplier or quotient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= MD_MUL;
      acc  <= '0;
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      op_q <= op;
      acc  <= '0;
      x    <= (op == MD_MUL) ? b : a;
      y    <= (op == MD_MUL) ? a : b;
      cnt  <= 6'(ITER_COUNT);
      busy <= 1'b1;
    end else if (busy) begin
      if (op_q == MD_MUL) begin
        if (x[0]) acc <= acc + y;
        y <= y << 1;
        x <= x >> 1;
      end else begin
        acc <= rem_next;
        x   <= {x[ALU_DATA_BITS-2:0], fits};
      end
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1) busy <= 1'b0;
    end
  end

  assign done   = busy && (cnt == 6'd1);
  assign result = (op_q == MD_DIVU) ? x : acc;

endmodule

// File: rtl/ext_alu_core.sv
// External ALU core: CSR-handshaked operand capture, combinational single-cycle
// ops, iterative MUL/DIVU/REMU, and a protectable registered result.
module ext_alu_core
  import ext_alu_core_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALU_DATA_BITS-1:0]    OP1,
  input  logic [ALU_DATA_BITS-1:0]    OP2,
  input  logic [ALU_OP_BITS-1:0]      ALUOP,
  input  logic [ALU_CSR_IN_BITS-1:0]  CSR_ALU_IN,
  output logic [ALU_DATA_BITS-1:0]    OP3,
  output logic [ALU_CSR_OUT_BITS-1:0] CSR_ALU_OUT
);

  state_e                   state;
  state_e                   state_next;
  logic [ALU_DATA_BITS-1:0] op1_q;
  logic [ALU_DATA_BITS-1:0] op2_q;
  logic [ALU_OP_BITS-1:0]   aluop_q;
  logic [5:0]               exec_cnt;

  logic                     iterative;
  logic                     md_start;
  logic                     md_done;
  md_op_e                   md_op;
  logic [ALU_DATA_BITS-1:0] md_result;
  logic [ALU_DATA_BITS-1:0] alu_result;
  logic [ALU_DATA_BITS-1:0] result;

  assign iterative = is_iterative(aluop_q);
  assign md_op     = (aluop_q == OP_MUL)  ? MD_MUL :
                     (aluop_q == OP_DIVU) ? MD_DIVU : MD_REMU;

  always_comb begin
    alu_result = '0;
    case (aluop_q)
      OP_ADD:  alu_result = op1_q + op2_q;
      OP_SUB:  alu_result = op1_q - op2_q;
      OP_AND:  alu_result = op1_q & op2_q;
      OP_OR:   alu_result = op1_q | op2_q;
      OP_XOR:  alu_result = op1_q ^ op2_q;
      OP_SLL:  alu_result = op1_q << op2_q[4:0];
      OP_SRL:  alu_result = op1_q >> op2_q[4:0];
      OP_SRA:  alu_result = $unsigned($signed(op1_q) >>> op2_q[4:0]);
      OP_SLT:  alu_result = {31'd0, $signed(op1_q) < $signed(op2_q)};
      OP_SLTU: alu_result = {31'd0, op1_q < op2_q};
      default: alu_result = '0;
    endcase
  end

  assign result = iterative ? md_result : alu_result;

  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    case (state)
      ST_IDLE:
        if (CSR_ALU_IN[CSR_IN_OP1]) state_next = ST_GET_OP2;
      ST_GET_OP2:
        if (CSR_ALU_IN[CSR_IN_OP2]) begin
          state_next = ST_EXEC;
          md_start   = iterative;
        end
      ST_EXEC:
        if (exec_cnt == 6'd0 && (!iterative || md_done)) state_next = ST_WRITE;
      ST_WRITE:
        if (!CSR_ALU_IN[CSR_IN_PROTECT]) state_next = ST_HOLD;
      ST_HOLD:
        if (CSR_ALU_IN[CSR_IN_PROTECT]) state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      CSR_ALU_OUT <= csr_out_code(ST_IDLE);
      op1_q       <= '0;
      op2_q       <= '0;
      aluop_q     <= '0;
      exec_cnt    <= '0;
      OP3         <= '0;
    end else begin
      state       <= state_next;
      CSR_ALU_OUT <= csr_out_code(state_next);
      if (state == ST_IDLE && CSR_ALU_IN[CSR_IN_OP1]) begin
        op1_q   <= OP1;
        aluop_q <= ALUOP;
      end
      if (state == ST_GET_OP2 && CSR_ALU_IN[CSR_IN_OP2]) begin
        op2_q    <= OP2;
        exec_cnt <= iterative ? 6'(ITER_COUNT - 1) : 6'd0;
      end else if (state == ST_EXEC && exec_cnt != 6'd0) begin
        exec_cnt <= exec_cnt - 6'd1;
      end
      if (state == ST_WRITE && !CSR_ALU_IN[CSR_IN_PROTECT]) OP3 <= result;
    end
  end

  // The iterative unit takes OP2 straight from the port since op2_q loads on the same edge.
  ext_alu_seqmd u_seqmd (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (md_op),
    .a      (op1_q),
    .b      (OP2),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_ext_alu_core.sv
// Directed self-checking bench for ext_alu_core: handshake timing, every opcode
// class, divide-by-zero, result protection and asynchronous reset abort.
module tb_ext_alu_core;
  import ext_alu_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [3:0]  ALUOP;
  logic [2:0]  CSR_ALU_IN;
  logic [31:0] OP3;
  logic [2:0]  CSR_ALU_OUT;

  int checks = 0;
  int fails  = 0;

  ext_alu_core dut (
    .clk         (clk),
    .reset       (reset),
    .OP1         (OP1),
    .OP2         (OP2),
    .ALUOP       (ALUOP),
    .CSR_ALU_IN  (CSR_ALU_IN),
    .OP3         (OP3),
    .CSR_ALU_OUT (CSR_ALU_OUT)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full unprotected transaction starting and ending in IDLE.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input bit multi);
    int lat;
    lat = multi ? 33 : 2;
    CSR_ALU_IN = 3'b010; OP1 = a; ALUOP = op; OP2 = 32'h5A5A_A5A5;
    tick();
    checkOutput({tag, " op2_rdy"}, 32'(CSR_ALU_OUT), 32'h2);
    CSR_ALU_IN = 3'b100; OP2 = b;
    tick();
    CSR_ALU_IN = 3'b000; OP1 = 32'h0BAD_0BAD; OP2 = 32'h0BAD_0BAD; ALUOP = 4'hF;
    repeat (lat - 1) tick();
    checkOutput({tag, " busy"}, 32'(CSR_ALU_OUT), 32'h0);
    tick();
    checkOutput({tag, " result"}, OP3, exp);
    checkOutput({tag, " valid"}, 32'(CSR_ALU_OUT), 32'h4);
    CSR_ALU_IN = 3'b001;
    tick();
    checkOutput({tag, " release"}, 32'(CSR_ALU_OUT), 32'h1);
    checkOutput({tag, " retain"}, OP3, exp);
    CSR_ALU_IN = 3'b000;
  endtask

  initial begin
    reset = 1'b1; OP1 = '0; OP2 = '0; ALUOP = '0; CSR_ALU_IN = '0;
    #1;
    checkOutput("reset out", 32'(CSR_ALU_OUT), 32'h1);
    checkOutput("reset op3", OP3, 32'h0);
    tick(); tick();
    reset = 1'b0;

    CSR_ALU_IN = 3'b100; OP2 = 32'd99;
    tick();
    checkOutput("early op2 ignored", 32'(CSR_ALU_OUT), 32'h1);
    CSR_ALU_IN = 3'b000;
    tick();

    applyStimulus("add",  OP_ADD,  32'd5,        32'd7,        32'd12,        1'b0);
    applyStimulus("sub",  OP_SUB,  32'd3,        32'd5,        32'hFFFF_FFFE, 1'b0);
    applyStimulus("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0);
    applyStimulus("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0);
    applyStimulus("sra",  OP_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0);
    applyStimulus("srl",  OP_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1'b0);
    applyStimulus("sll",  OP_SLL,  32'd1,        32'h0000_003F, 32'h8000_0000, 1'b0);
    applyStimulus("and",  OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    applyStimulus("or",   OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    applyStimulus("xor",  OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0);
    applyStimulus("op11", 4'd11,   32'd5,        32'd7,        32'd0,         1'b0);
    applyStimulus("mul",  OP_MUL,  32'd1234,     32'd5678,     32'd7006652,   1'b1);
    applyStimulus("mulw", OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'd0,       1'b1);
    applyStimulus("mulm", OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,       1'b1);
    applyStimulus("divu", OP_DIVU, 32'd100,      32'd7,        32'd14,        1'b1);
    applyStimulus("remu", OP_REMU, 32'd100,      32'd7,        32'd2,         1'b1);
    applyStimulus("div0", OP_DIVU, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
    applyStimulus("rem0", OP_REMU, 32'd9,        32'd0,        32'd9,         1'b1);
    applyStimulus("add2", OP_ADD,  32'd5,        32'd7,        32'd12,        1'b0);

    // Protected result: 20-3 must wait in WRITE until protect drops.
    CSR_ALU_IN = 3'b011; OP1 = 32'd20; ALUOP = OP_SUB;
    tick();
    CSR_ALU_IN = 3'b101; OP2 = 32'd3;
    tick();
    CSR_ALU_IN = 3'b001;
    tick(); tick(); tick();
    checkOutput("protect stall out", 32'(CSR_ALU_OUT), 32'h0);
    checkOutput("protect keeps op3", OP3, 32'd12);
    CSR_ALU_IN = 3'b000;
    tick();
    checkOutput("unprotect result", OP3, 32'd17);
    checkOutput("unprotect valid", 32'(CSR_ALU_OUT), 32'h4);
    CSR_ALU_IN = 3'b001;
    tick();
    checkOutput("protect release", 32'(CSR_ALU_OUT), 32'h1);
    CSR_ALU_IN = 3'b000;

    // Both strobes in IDLE: OP1 only, so the later OP2=7 is the divisor.
    CSR_ALU_IN = 3'b110; OP1 = 32'd100; OP2 = 32'd1; ALUOP = OP_DIVU;
    tick();
    checkOutput("both strobes op1 only", 32'(CSR_ALU_OUT), 32'h2);
    CSR_ALU_IN = 3'b100; OP2 = 32'd7;
    tick();
    CSR_ALU_IN = 3'b000;
    repeat (33) tick();
    checkOutput("both strobes result", OP3, 32'd14);
    CSR_ALU_IN = 3'b001;
    tick();
    CSR_ALU_IN = 3'b000;

    // Asynchronous reset ten cycles into a multiply.
    CSR_ALU_IN = 3'b010; OP1 = 32'd1234; ALUOP = OP_MUL;
    tick();
    CSR_ALU_IN = 3'b100; OP2 = 32'd5678;
    tick();
    CSR_ALU_IN = 3'b000;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("abort out", 32'(CSR_ALU_OUT), 32'h1);
    checkOutput("abort op3", OP3, 32'h0);
    tick();
    reset = 1'b0;
    CSR_ALU_IN = 3'b100; OP2 = 32'd7;
    tick();
    CSR_ALU_IN = 3'b000;
    checkOutput("post-reset op2 ignored", 32'(CSR_ALU_OUT), 32'h1);
    repeat (34) tick();
    checkOutput("no stale result", OP3, 32'h0);
    applyStimulus("fresh add", OP_ADD, 32'd40, 32'd2, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
